epu_sched: RTL and testbench

EPU_SCHED -- requirements
Module: epu_sched

---
 rtl/epu_sched.sv | 109 ++++++++++
 tb/tb_epu_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/epu_sched.sv
// epu_sched: round-robin scheduler that hands EPU runs to the CPU or the DMA.
// It latches the winner's base address, pulses epu_start, waits for epu_end
// with a timeout, then acks the owner and counts successful runs.
module epu_sched #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_cpu,
  input  logic             req_dma,
  input  logic [11:0]      base_cpu,
  input  logic [11:0]      base_dma,
  output logic [11:0]      epu_base,
  output logic             epu_start,
  input  logic             epu_end,
  output logic             ack_cpu,
  output logic             ack_dma,
  output logic             err,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] run_cnt
);

  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t            state;
  logic              prio;      // 0 = CPU wins a tie, 1 = DMA wins a tie
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  logic              win;

  // Arbitration: a lone requester always wins; a tie goes to the pointer.
  always_comb begin
    // NOTE: assign a default first so every path drives win and no latch is inferred.
    win = 1'b0;
    if (req_cpu && req_dma) win = prio;
    else                    win = req_dma;
  end

  // Scheduler FSM with registered outputs and synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state     <= IDLE;
      prio      <= 1'b0;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      run_cnt   <= '0;
      epu_start <= 1'b0;
      ack_cpu   <= 1'b0;
      ack_dma   <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= 1'b0;
      epu_base  <= 12'h000;
    end else begin
      case (state)
        IDLE: begin
          if (req_cpu || req_dma) begin
            grant_id  <= win;
            epu_base  <= win ? base_dma : base_cpu;
            prio      <= ~win;
            epu_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          epu_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (epu_end) begin
            // Completion beats a simultaneous timeout.
            err_q   <= 1'b0;
            err     <= 1'b0;
            ack_cpu <= ~grant_id;
            ack_dma <= grant_id;
            state   <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            err_q   <= 1'b1;
            err     <= 1'b1;
            ack_cpu <= ~grant_id;
            ack_dma <= grant_id;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          ack_cpu <= 1'b0;
          ack_dma <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
          if (!err_q) run_cnt <= run_cnt + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epu_sched.sv
// tb_epu_sched: directed stimulus with a scoreboard; a negedge monitor pops
// the expected owner/err/base/count whenever the scheduler raises an ack.
module tb_epu_sched;

  localparam int TO    = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             req_cpu, req_dma;
  logic [11:0]      base_cpu, base_dma;
  logic [11:0]      epu_base;
  logic             epu_start, epu_end;
  logic             ack_cpu, ack_dma, err, busy, grant_id;
  logic [CNT_W-1:0] run_cnt;

  typedef struct packed {
    logic             who;
    logic             err;
    logic [11:0]      base;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;
  logic             cnt_pending = 1'b0;
  logic [CNT_W-1:0] cnt_exp = '0;

  epu_sched #(.TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_cpu(req_cpu), .req_dma(req_dma),
    .base_cpu(base_cpu), .base_dma(base_dma),
    .epu_base(epu_base), .epu_start(epu_start), .epu_end(epu_end),
    .ack_cpu(ack_cpu), .ack_dma(ack_dma), .err(err), .busy(busy),
    .grant_id(grant_id), .run_cnt(run_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every ack against the scoreboard, then the count a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (cnt_pending) begin
      check("run_cnt_after_ack", 32'(run_cnt), 32'(cnt_exp));
      cnt_pending = 1'b0;
    end
    if (ack_cpu || ack_dma) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got cpu=%0b dma=%0b expected none at %0t",
                 ack_cpu, ack_dma, $time);
      end else begin
        e = sb.pop_front();
        check("ack_owner", {30'd0, ack_dma, ack_cpu}, e.who ? 32'd2 : 32'd1);
        check("ack_err", 32'(err), 32'(e.err));
        check("ack_base", 32'(epu_base), 32'(e.base));
        cnt_pending = 1'b1;
        cnt_exp     = e.cnt;
      end
    end else if (err) begin
      check("err_without_ack", 32'(err), 32'd0);
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_cnt = '0;
  endtask

  // Called at #1 in an IDLE cycle with requests already driven. Returns at #1
  // in the DONE (ack) cycle. end_at = WAIT cycle (1-based) carrying epu_end,
  // 0 = never (timeout).
  task automatic run_check(input logic who, input logic [11:0] base,
                           input int end_at, input logic exp_err);
    exp_t e;
    int   c;
    bit   seen;
    if (!exp_err) exp_cnt = exp_cnt + 1'b1;
    e.who = who; e.err = exp_err; e.base = base; e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
    check("start_pulse", 32'(epu_start), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_grant", 32'(grant_id), 32'(who));
    check("start_base", 32'(epu_base), 32'(base));
    seen = 1'b0;
    c    = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k == 0) check("start_one_cycle", 32'(epu_start), 32'd0);
      if (ack_cpu || ack_dma) begin
        epu_end = 1'b0;
        seen    = 1'b1;
        c       = k;
        break;
      end
      epu_end = (k + 1 == end_at);
    end
    epu_end = 1'b0;
    check("ack_seen", 32'(seen), 32'd1);
    check("ack_latency", 32'(c), 32'((end_at != 0) ? end_at : TO));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_cpu = 1'b0; req_dma = 1'b0;
    base_cpu = 12'h000; base_dma = 12'h000; epu_end = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset state.
    check("rst_start", 32'(epu_start), 32'd0);
    check("rst_acks", {30'd0, ack_dma, ack_cpu}, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_base", 32'(epu_base), 32'd0);
    check("rst_cnt", 32'(run_cnt), 32'd0);

    // Single CPU run: req cycle 0, epu_end cycle 7 (WAIT cycle 6), ack cycle 8.
    req_cpu = 1'b1; base_cpu = 12'h040; base_dma = 12'hFFF;
    run_check(1'b0, 12'h040, 6, 1'b0);
    @(posedge clk); #1;
    req_cpu = 1'b0;

    // Spurious epu_end in IDLE.
    epu_end = 1'b1;
    @(posedge clk); #1;
    epu_end = 1'b0;
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_start", 32'(epu_start), 32'd0);
    @(posedge clk); #1;
    check("spur_busy2", 32'(busy), 32'd0);
    check("spur_cnt", 32'(run_cnt), 32'd1);

    // Timeout: DMA run, no epu_end.
    req_dma = 1'b1; base_dma = 12'h123; base_cpu = 12'h456;
    run_check(1'b1, 12'h123, 0, 1'b1);
    @(posedge clk); #1;
    req_dma = 1'b0;

    // Boundary: epu_end in the last WAIT cycle wins over the timeout.
    req_cpu = 1'b1; base_cpu = 12'h7A5; base_dma = 12'h0F0;
    run_check(1'b0, 12'h7A5, TO, 1'b0);
    @(posedge clk); #1;
    req_cpu = 1'b0;
    check("boundary_cnt", 32'(run_cnt), 32'd2);

    // Reset mid-run: CPU granted (pointer moves to DMA), reset in WAIT.
    req_cpu = 1'b1; base_cpu = 12'h3C0; base_dma = 12'h111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun_busy_before", 32'(busy), 32'd1);
    do_reset();
    req_cpu = 1'b0;
    check("midrun_busy", 32'(busy), 32'd0);
    check("midrun_base", 32'(epu_base), 32'd0);
    check("midrun_cnt", 32'(run_cnt), 32'd0);
    @(posedge clk); #1;
    epu_end = 1'b1;
    @(posedge clk); #1;
    epu_end = 1'b0;
    check("late_end_busy", 32'(busy), 32'd0);
    check("late_end_start", 32'(epu_start), 32'd0);

    // Contention from reset: pointer back at CPU, grants alternate.
    req_cpu = 1'b1; req_dma = 1'b1; base_cpu = 12'h0A1; base_dma = 12'hD02;
    for (int i = 0; i < 4; i++) begin
      run_check(i[0], i[0] ? 12'hD02 : 12'h0A1, 2 + i, 1'b0);
      @(posedge clk); #1;
    end
    req_cpu = 1'b0; req_dma = 1'b0;
    check("contention_cnt", 32'(run_cnt), 32'd4);

    // Wrap: 16 successful runs from a cleared counter return it to 0.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req_cpu  = ~i[0];
      req_dma  = i[0];
      base_cpu = 12'h100 + 12'(i);
      base_dma = 12'h200 + 12'(i);
      run_check(i[0], i[0] ? 12'h200 + 12'(i) : 12'h100 + 12'(i), 1 + (i % 3), 1'b0);
      @(posedge clk); #1;
      req_cpu = 1'b0; req_dma = 1'b0;
    end
    check("wrap_cnt", 32'(run_cnt), 32'd0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
